lfsr_period_monitor: RTL and testbench

//  Downstream consumer of the LFSR top-level output (lfsr_out of static or configurable LFSR).
//  On a start request, captures a reference state and counts enabled steps until that state recurs.

---
 rtl/lfsr_period_monitor_if.sv | 22 ++
 rtl/lfsr_period_monitor.sv | 119 +++++++++++
 tb/tb_lfsr_period_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_period_monitor_if.sv
// Result channel of the LFSR period monitor: valid/ready handshake carrying
// the measured period and its status flags.
interface lfsr_period_monitor_if #(
  parameter int CW = 4
);
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] period;
  logic          maximal;
  logic          lockup;
  logic          timeout;

  modport master (
    output res_valid, period, maximal, lockup, timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid, period, maximal, lockup, timeout,
    output res_ready
  );
endinterface

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an upstream LFSR state: captures a reference
// on the first enabled sample, counts enabled samples until it recurs, then reports.
module lfsr_period_monitor #(
  parameter  int WIDTH   = 3,
  parameter  int TIMEOUT = 2**WIDTH,
  localparam int CW      = $clog2(TIMEOUT+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      lfsr_in,
  output logic                  busy,
  lfsr_period_monitor_if.master res
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_ref;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_period;
  logic             r_busy;
  logic             r_res_valid;
  logic             r_maximal;
  logic             r_lockup;
  logic             r_timeout;

  logic w_match;
  logic w_zero;
  logic w_cnt_end;
  logic w_cnt_max;

  assign w_match   = (lfsr_in == r_ref);
  assign w_zero    = (lfsr_in == '0);
  assign w_cnt_end = (r_cnt == CW'(TIMEOUT));
  assign w_cnt_max = (r_cnt == CW'(2**WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ref       <= '0;
      r_cnt       <= '0;
      r_period    <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_maximal   <= 1'b0;
      r_lockup    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CAPTURE;
            r_busy    <= 1'b1;
            r_period  <= '0;
            r_maximal <= 1'b0;
            r_lockup  <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_CAPTURE: begin
          // An all-zero reference can never advance, so report lock-up at once.
          if (enable) begin
            r_ref <= lfsr_in;
            if (w_zero) begin
              r_lockup    <= 1'b1;
              r_period    <= '0;
              r_busy      <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_cnt   <= CW'(1);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (enable) begin
            if (w_match) begin
              r_period    <= r_cnt;
              r_maximal   <= w_cnt_max;
              r_busy      <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_cnt_end) begin
              r_timeout   <= 1'b1;
              r_period    <= '0;
              r_busy      <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          // Result fields stay frozen here; start is deliberately not looked at.
          if (res.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign res.res_valid = r_res_valid;
  assign res.period    = r_period;
  assign res.maximal   = r_maximal;
  assign res.lockup    = r_lockup;
  assign res.timeout   = r_timeout;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Scoreboard bench for lfsr_period_monitor (WIDTH=3, TIMEOUT=8): directed LFSR
// sequences push expected results; a negedge monitor compares every presented result.
module tb_lfsr_period_monitor;

  localparam int WIDTH   = 3;
  localparam int TIMEOUT = 8;
  localparam int CW      = 4;

  typedef struct packed {
    logic [CW-1:0] period;
    logic          maximal;
    logic          lockup;
    logic          timeout;
  } res_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             enable;
  logic [WIDTH-1:0] lfsr_in;
  logic             busy;

  lfsr_period_monitor_if #(.CW(CW)) rif ();

  lfsr_period_monitor #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .enable  (enable),
    .lfsr_in (lfsr_in),
    .busy    (busy),
    .res     (rif.master)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  res_t             exp_q[$];
  logic [WIDTH-1:0] seq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a result is presented it must equal the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1 && rif.res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: got period=%0d lockup=%0b timeout=%0b, expected no result",
                 rif.period, rif.lockup, rif.timeout);
      end else begin
        chk("result", int'({rif.period, rif.maximal, rif.lockup, rif.timeout}), int'(exp_q[0]));
        if (rif.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic en, input logic [WIDTH-1:0] v);
    enable  = en;
    lfsr_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic start_meas();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  // Drive seq with `gap` disabled cycles between samples; check valid timing.
  task automatic run_seq(input string name, input int gap);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == seq.size() - 1) chk({name, "_valid_early"}, rif.res_valid, 0);
      step(1'b1, seq[i]);
      if (i != seq.size() - 1)
        for (int g = 0; g < gap; g++) step(1'b0, '0);
    end
    chk({name, "_valid_latency"}, rif.res_valid, 1);
    chk({name, "_busy_done"}, busy, 0);
    enable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (rif.res_valid === 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_drain"}, rif.res_valid, 0);
  endtask

  task automatic case1(input string name, input int gap);
    exp_q.push_back('{period: 4'd7, maximal: 1'b1, lockup: 1'b0, timeout: 1'b0});
    start_meas();
    seq = '{3'd1, 3'd4, 3'd6, 3'd7, 3'd3, 3'd5, 3'd2, 3'd1};
    run_seq(name, gap);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    enable        = 1'b0;
    lfsr_in       = '0;
    rif.res_ready = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", rif.res_valid, 0);
    chk("rst_fields", int'({rif.period, rif.maximal, rif.lockup, rif.timeout}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, '0);

    // 1: maximal-length sequence
    case1("c1", 0);
    wait_idle("c1");

    // 2: all-zero lock-up
    exp_q.push_back('{period: 4'd0, maximal: 1'b0, lockup: 1'b1, timeout: 1'b0});
    start_meas();
    seq = '{3'd0};
    run_seq("c2", 0);
    wait_idle("c2");

    // 3: short periods 2 and 1
    exp_q.push_back('{period: 4'd2, maximal: 1'b0, lockup: 1'b0, timeout: 1'b0});
    start_meas();
    seq = '{3'd5, 3'd2, 3'd5};
    run_seq("c3a", 0);
    wait_idle("c3a");
    exp_q.push_back('{period: 4'd1, maximal: 1'b0, lockup: 1'b0, timeout: 1'b0});
    start_meas();
    seq = '{3'd6, 3'd6};
    run_seq("c3b", 0);
    wait_idle("c3b");

    // 4: reference never recurs -> timeout after 8 compared samples
    exp_q.push_back('{period: 4'd0, maximal: 1'b0, lockup: 1'b0, timeout: 1'b1});
    start_meas();
    seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
    run_seq("c4", 0);
    wait_idle("c4");

    // 5: enable gaps, back-pressure, start held through DONE and the handshake
    rif.res_ready = 1'b0;
    case1("c5", 3);
    start = 1'b1;
    repeat (5) step(1'b0, '0);
    chk("c5_valid_held", rif.res_valid, 1);
    rif.res_ready = 1'b1;
    step(1'b0, '0);
    start = 1'b0;
    chk("c5_valid_drop", rif.res_valid, 0);
    step(1'b0, '0);
    chk("c5_start_ignored", busy, 0);
    step(1'b0, '0);
    chk("c5_still_idle", busy, 0);

    // 6: asynchronous reset in RUN, then rerun case 1
    start_meas();
    step(1'b1, 3'd1);
    step(1'b1, 3'd4);
    step(1'b1, 3'd6);
    step(1'b1, 3'd7);
    chk("c6_busy_run", busy, 1);
    reset = 1'b0;
    #2;
    chk("c6_async_busy", busy, 0);
    chk("c6_async_valid", rif.res_valid, 0);
    chk("c6_async_fields", int'({rif.period, rif.maximal, rif.lockup, rif.timeout}), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 3'd3);
    chk("c6_idle_after_reset", busy, 0);
    case1("c6", 0);
    wait_idle("c6");

    repeat (2) step(1'b0, '0);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
